// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_pkg
// Brief    : Shared constants and types for the register-file write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int ZERO_REG  = 31;
    localparam int NREGS     = 32;
    localparam int WIDTH     = 64;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [WIDTH-1:0]     word_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; searches upward from Last+1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int LAST_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]   Req,
    input  logic [LAST_W-1:0] Last,
    input  logic              Enable,
    output logic [NREQ-1:0]   Grant
);

    always_comb begin
        logic found;
        Grant = '0;
        found = 1'b0;
        // Offsets 1..NREQ visit every requester once, the last-granted one last.
        for (int off = 1; off <= NREQ; off++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (Enable && !found && Req[j] &&
                    (j == ((int'(Last) + off) % NREQ))) begin
                    Grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Round-robin sharing of the register-file write port, with Busy map.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int NREQ     = 3,
    parameter int WIDTH    = regfile_write_arbiter_pkg::WIDTH,
    parameter int NREGS    = regfile_write_arbiter_pkg::NREGS,
    parameter int ZERO_REG = regfile_write_arbiter_pkg::ZERO_REG
) (
    input  logic                                          Clk,
    input  logic                                          Rst_n,
    input  logic                                          Stall,
    input  logic [NREQ-1:0]                               Req,
    input  logic [NREQ*regfile_write_arbiter_pkg::REG_IDX_W-1:0] RWIn,
    input  logic [NREQ*WIDTH-1:0]                         BusWIn,
    output logic [NREQ-1:0]                               Grant,
    output logic                                          RegWr,
    output logic [regfile_write_arbiter_pkg::REG_IDX_W-1:0] RW,
    output logic [WIDTH-1:0]                              BusW,
    output logic [NREGS-1:0]                              Busy,
    output logic                                          Idle
);
    import regfile_write_arbiter_pkg::*;

    localparam int LAST_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [LAST_W-1:0] r_last;
    logic [LAST_W-1:0] w_gidx;
    reg_idx_t          w_rw;
    logic [WIDTH-1:0]  w_data;

    // Grants are held off while reset is asserted so nothing is consumed.
    rr_arbiter #(
        .NREQ   (NREQ),
        .LAST_W (LAST_W)
    ) u_rr_arbiter (
        .Req    (Req),
        .Last   (r_last),
        .Enable (Rst_n && !Stall),
        .Grant  (Grant)
    );

    always_comb begin
        w_gidx = '0;
        w_rw   = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (Grant[i]) begin
                w_gidx = LAST_W'(i);
                w_rw   = RWIn[REG_IDX_W*i +: REG_IDX_W];
                w_data = BusWIn[WIDTH*i +: WIDTH];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_last <= LAST_W'(NREQ-1);
            RegWr  <= 1'b0;
            RW     <= '0;
            BusW   <= '0;
        end else if (|Grant) begin
            r_last <= w_gidx;
            RW     <= w_rw;
            BusW   <= w_data;
            RegWr  <= (w_rw != reg_idx_t'(ZERO_REG));
        end else begin
            RegWr  <= 1'b0;
        end
    end

    always_comb begin
        Busy = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (Req[i] && (RWIn[REG_IDX_W*i +: REG_IDX_W] == reg_idx_t'(r)))
                    Busy[r] = 1'b1;
            end
            if (RegWr && (RW == reg_idx_t'(r)))
                Busy[r] = 1'b1;
        end
        Busy[ZERO_REG] = 1'b0;
        if (!Rst_n)
            Busy = '0;
    end

    assign Idle = !Rst_n || ((Req == '0) && !RegWr);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Brief    : Scoreboard bench for regfile_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    typedef struct {
        logic        wr;
        logic [4:0]  rw;
        logic [63:0] data;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Stall = 1'b0;
    logic [2:0]    Req = '0;
    logic [14:0]   RWIn = '0;
    logic [191:0]  BusWIn = '0;
    logic [2:0]    Grant;
    logic          RegWr;
    logic [4:0]    RW;
    logic [63:0]   BusW;
    logic [31:0]   Busy;
    logic          Idle;

    int            n_vec = 0;
    int            n_err = 0;
    exp_t          sb[$];
    int            m_last = 2;
    logic [4:0]    m_rw = '0;
    logic [63:0]   m_data = '0;
    logic [63:0]   rf [0:31];

    regfile_write_arbiter dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Stall  (Stall),
        .Req    (Req),
        .RWIn   (RWIn),
        .BusWIn (BusWIn),
        .Grant  (Grant),
        .RegWr  (RegWr),
        .RW     (RW),
        .BusW   (BusW),
        .Busy   (Busy),
        .Idle   (Idle)
    );

    always #5 Clk = ~Clk;

    // Register file model: captures on the negedge following the issue posedge.
    always @(negedge Clk) if (RegWr) rf[RW] <= BusW;

    for (genvar gi = 0; gi < 3; gi++) begin : g_req_stable
        assert property (@(posedge Clk) disable iff (!Rst_n)
            (Req[gi] && !Grant[gi]) |=> (Req[gi] && $stable(RWIn[5*gi +: 5])))
            else $error("requester %0d changed its request before being granted", gi);
    end

    function automatic logic [2:0] mgrant(input logic [2:0] req, input int last, input logic st);
        logic [2:0] g;
        g = '0;
        if (st || req == 3'b000) return g;
        for (int k = 1; k <= 3; k++) begin
            int j;
            j = (last + k) % 3;
            if (req[j]) begin
                g[j] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_last = 2;
        m_rw   = '0;
        m_data = '0;
        sb.delete();
    endtask

    // Advance one clock, pushing the model's expected issue-stage contents.
    task automatic tick();
        exp_t       e;
        logic [2:0] g;
        g = Rst_n ? mgrant(Req, m_last, Stall) : 3'b000;
        e.wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (g[i]) begin
                m_last = i;
                m_rw   = RWIn[5*i +: 5];
                m_data = BusWIn[64*i +: 64];
                e.wr   = (m_rw != 5'd31);
            end
        end
        e.rw   = m_rw;
        e.data = m_data;
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        Req   = 3'b111;
        RWIn  = {5'd3, 5'd2, 5'd1};
        BusWIn = {64'hC3, 64'hB2, 64'hA1};
        model_reset();
        @(posedge Clk);
        #1;
        n_vec++; if (Grant !== 3'b000) begin n_err++; $display("FAIL reset_grant: got %b want 000", Grant); end
        n_vec++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL reset_regwr: got %b want 0", RegWr); end
        n_vec++; if (Busy !== 32'h0) begin n_err++; $display("FAIL reset_busy: got %h want 0", Busy); end
        n_vec++; if (Idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", Idle); end
        n_vec++; if ({RW, BusW} !== 69'h0) begin n_err++; $display("FAIL reset_port: got rw=%0d data=%h want 0", RW, BusW); end
        Rst_n = 1'b1;
        #1;
        n_vec++; if (Grant !== 3'b001) begin n_err++; $display("FAIL reset_first_grant: got %b want 001", Grant); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        for (int c = 0; c < 6; c++) begin
            logic [2:0] want;
            want = '0;
            want[c % 3] = 1'b1;
            n_vec++; if (Grant !== want) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", c, Grant, want); end
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({RegWr, RW, BusW} !== {e.wr, e.rw, e.data} || RW !== 5'(c % 3 + 1)) begin
                n_err++;
                $display("FAIL rr_issue[%0d]: got wr=%b rw=%0d data=%h want wr=%b rw=%0d data=%h",
                         c, RegWr, RW, BusW, e.wr, c % 3 + 1, e.data);
            end
        end
        // Requesters 0 and 1 were left pending; let them drain.
        for (int c = 0; c < 3; c++) begin
            Req = (c == 0) ? 3'b011 : (c == 1) ? 3'b010 : 3'b000;
            #1;
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({RegWr, RW, BusW} !== {e.wr, e.rw, e.data}) begin
                n_err++;
                $display("FAIL rr_drain[%0d]: got wr=%b rw=%0d data=%h want wr=%b rw=%0d data=%h",
                         c, RegWr, RW, BusW, e.wr, e.rw, e.data);
            end
        end
        Req = 3'b000;
    endtask

    task automatic test_single_write();
        exp_t e;
        RWIn[5 +: 5]     = 5'd5;
        BusWIn[64 +: 64] = 64'hDEAD_BEEF;
        Req = 3'b010;
        #1;
        n_vec++; if (Grant !== 3'b010) begin n_err++; $display("FAIL single_grant: got %b want 010", Grant); end
        n_vec++; if (Busy[5] !== 1'b1) begin n_err++; $display("FAIL single_busy_req: got %b want 1", Busy[5]); end
        tick();
        Req = 3'b000;
        #1;
        e = sb.pop_front();
        n_vec++;
        if ({RegWr, RW, BusW} !== {1'b1, 5'd5, 64'hDEAD_BEEF} || {RegWr, RW, BusW} !== {e.wr, e.rw, e.data}) begin
            n_err++;
            $display("FAIL single_issue: got wr=%b rw=%0d data=%h want wr=1 rw=5 data=deadbeef", RegWr, RW, BusW);
        end
        n_vec++; if (Busy[5] !== 1'b1) begin n_err++; $display("FAIL single_busy_issue: got %b want 1", Busy[5]); end
        tick();
        e = sb.pop_front();
        n_vec++;
        if ({RegWr, RW, BusW} !== {e.wr, e.rw, e.data}) begin
            n_err++;
            $display("FAIL single_drain: got wr=%b rw=%0d data=%h want wr=%b rw=%0d data=%h",
                     RegWr, RW, BusW, e.wr, e.rw, e.data);
        end
        n_vec++; if (Busy[5] !== 1'b0) begin n_err++; $display("FAIL single_busy_clear: got %b want 0", Busy[5]); end
        n_vec++; if (Idle !== 1'b1) begin n_err++; $display("FAIL single_idle: got %b want 1", Idle); end
    endtask

    task automatic test_same_dest();
        exp_t e;
        RWIn[0 +: 5]     = 5'd7;
        RWIn[5 +: 5]     = 5'd7;
        BusWIn[0 +: 64]  = 64'hAAAA_0000_0000_000A;
        BusWIn[64 +: 64] = 64'hBBBB_0000_0000_000B;
        Req = 3'b011;
        #1;
        for (int c = 0; c < 2; c++) begin
            tick();
            Req = (c == 0) ? 3'b010 : 3'b000;
            e = sb.pop_front();
            n_vec++;
            if ({RegWr, RW, BusW} !== {e.wr, e.rw, e.data} ||
                BusW !== ((c == 0) ? 64'hAAAA_0000_0000_000A : 64'hBBBB_0000_0000_000B)) begin
                n_err++;
                $display("FAIL samedst_issue[%0d]: got wr=%b rw=%0d data=%h want wr=%b rw=%0d data=%h",
                         c, RegWr, RW, BusW, e.wr, e.rw, e.data);
            end
        end
        @(negedge Clk);
        #1;
        n_vec++; if (rf[7] !== 64'hBBBB_0000_0000_000B) begin n_err++; $display("FAIL samedst_rf: got %h want bbbb00000000000b", rf[7]); end
        tick();
        void'(sb.pop_front());
    endtask

    task automatic test_zero_reg();
        exp_t e;
        RWIn[10 +: 5]     = 5'd31;
        BusWIn[128 +: 64] = 64'h5555;
        Req = 3'b100;
        #1;
        n_vec++; if (Grant !== 3'b100) begin n_err++; $display("FAIL zero_grant: got %b want 100", Grant); end
        n_vec++; if (Busy[31] !== 1'b0) begin n_err++; $display("FAIL zero_busy_req: got %b want 0", Busy[31]); end
        tick();
        Req = 3'b000;
        #1;
        e = sb.pop_front();
        n_vec++;
        if (RegWr !== 1'b0 || {RegWr, RW, BusW} !== {e.wr, e.rw, e.data}) begin
            n_err++;
            $display("FAIL zero_issue: got wr=%b rw=%0d data=%h want wr=0 rw=%0d data=%h", RegWr, RW, BusW, e.rw, e.data);
        end
        n_vec++; if (Busy[31] !== 1'b0) begin n_err++; $display("FAIL zero_busy_issue: got %b want 0", Busy[31]); end
    endtask

    task automatic test_stall();
        exp_t e;
        RWIn[0 +: 5]    = 5'd12;
        BusWIn[0 +: 64] = 64'h0C0C;
        Stall = 1'b1;
        Req   = 3'b001;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (Grant !== 3'b000) begin n_err++; $display("FAIL stall_grant[%0d]: got %b want 000", c, Grant); end
            n_vec++; if (Busy[12] !== 1'b1) begin n_err++; $display("FAIL stall_busy[%0d]: got %b want 1", c, Busy[12]); end
            tick();
            e = sb.pop_front();
            n_vec++;
            if (RegWr !== 1'b0 || {RegWr, RW, BusW} !== {e.wr, e.rw, e.data}) begin
                n_err++;
                $display("FAIL stall_issue[%0d]: got wr=%b rw=%0d want wr=0 rw=%0d", c, RegWr, RW, e.rw);
            end
        end
        Stall = 1'b0;
        #1;
        n_vec++; if (Grant !== 3'b001) begin n_err++; $display("FAIL stall_release_grant: got %b want 001", Grant); end
        tick();
        Req = 3'b000;
        e = sb.pop_front();
        n_vec++;
        if ({RegWr, RW, BusW} !== {1'b1, 5'd12, 64'h0C0C} || {RegWr, RW, BusW} !== {e.wr, e.rw, e.data}) begin
            n_err++;
            $display("FAIL stall_release_issue: got wr=%b rw=%0d data=%h want wr=1 rw=12 data=c0c", RegWr, RW, BusW);
        end
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        logic [63:0] saved;
        RWIn[5 +: 5]     = 5'd9;
        BusWIn[64 +: 64] = 64'h1234;
        Req = 3'b010;
        #1;
        tick();
        Req = 3'b000;
        e = sb.pop_front();
        n_vec++;
        if (RegWr !== 1'b1 || {RegWr, RW, BusW} !== {e.wr, e.rw, e.data}) begin
            n_err++;
            $display("FAIL midrst_issue: got wr=%b rw=%0d want wr=1 rw=9", RegWr, RW);
        end
        saved = rf[9];
        Rst_n = 1'b0;
        #1;
        n_vec++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL midrst_regwr: got %b want 0", RegWr); end
        model_reset();
        Rst_n = 1'b1;
        Req   = 3'b011;
        RWIn[0 +: 5] = 5'd4;
        #1;
        n_vec++; if (Grant !== 3'b001) begin n_err++; $display("FAIL midrst_last: got %b want 001", Grant); end
        Req = 3'b000;
        @(negedge Clk);
        #1;
        n_vec++; if (rf[9] !== saved) begin n_err++; $display("FAIL midrst_dropped: got %h want %h", rf[9], saved); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_write();
        test_same_dest();
        test_zero_reg();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
